// File: rtl/axi4lite_master_single_txn.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI4-Lite write
// or read out, one response back, with a busy-cycle timeout for a dead slave.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W presented; each drops on its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_RESP | RREADY high, waiting for RVALID
// RSP     | rsp_valid high, outputs frozen until rsp_ready
module axi4lite_master_single_txn #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 11,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,

  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]                    state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          bready_q, bready_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rready_q, rready_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;
  logic                          rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]              busy_cnt_q, busy_cnt_d;

  logic busy;
  logic resp_hs;
  logic timeout_hit;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    busy = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
           (state_q == S_RD_REQ) || (state_q == S_RD_RESP);
    busy_cnt_d  = busy ? (busy_cnt_q + CNT_W'(1)) : busy_cnt_q;
    resp_hs     = ((state_q == S_WR_RESP) && M_AXI_BVALID) ||
                  ((state_q == S_RD_RESP) && M_AXI_RVALID);
    timeout_hit = (TIMEOUT_CYCLES != 0) && busy && (busy_cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          wdata_d    = cmd_wdata;
          wstrb_d    = cmd_wstrb;
          busy_cnt_d = '0;
          if (cmd_write) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W may complete in either order or together.
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = M_AXI_BRESP;
          rsp_timeout_d = 1'b0;
          state_d       = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (M_AXI_RVALID) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = M_AXI_RDATA;
          rsp_resp_d    = M_AXI_RRESP;
          rsp_timeout_d = 1'b0;
          state_d       = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A response handshake in the final busy cycle still counts as a real
    // completion; otherwise the timeout abandons the bus and reports 2'b11.
    if (timeout_hit && !resp_hs) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b11;
      rsp_timeout_d = 1'b1;
      state_d       = S_RSP;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      busy_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_cnt_q    <= busy_cnt_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/axi4lite_master_single_txn.md
# axi4lite_master_single_txn

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command port into one AXI4-Lite write or read transaction and returns the response on a valid/ready response port. It is the host-side counterpart of the firmware register slave: benches and on-chip sequencers use it to drive register writes and readbacks over the same 64-bit, 11-bit-address AXI4-Lite bus. A cycle timeout recovers the command port if the slave never responds.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 64, data bus width; strobe width is C_M_AXI_DATA_WIDTH/8.
- C_M_AXI_ADDR_WIDTH, 11, address bus width.
- TIMEOUT_CYCLES, 1024, busy-cycle limit per transaction; 0 disables the timeout.

Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- cmd_valid / cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid / rsp_ready  out/in  1/1  response handshake.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP; 2'b11 on timeout.
- rsp_timeout  out  1  transaction ended by timeout.
- M_AXI_AW*/W*/B*/AR*/R*: full AXI4-Lite master channel set; AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARPROT, ARVALID, RREADY are outputs; AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID are inputs. Widths follow the parameters.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register addr/wdata/wstrb and go to WR_REQ or RD_REQ per cmd_write.
- WR_REQ: AWVALID and WVALID both asserted on entry. Each channel drops independently on its own handshake (VALID&READY). Go to WR_RESP when both have completed, including the case where both complete in the same cycle.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and set rsp_rdata=0. Go to RSP.
- RD_REQ: ARVALID=1 until ARREADY. Then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP. Go to RSP.
- RSP: rsp_valid=1. Outputs are held stable until rsp_ready. Then go to IDLE.
- Addresses, data and strobes are held stable while the matching VALID is high.
- AWPROT=ARPROT=3'b000. Unaligned addresses are passed through unmodified.
- Timeout:
  - A busy counter clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ or RD_RESP.
  - When it reaches TIMEOUT_CYCLES (if nonzero), all AXI VALID/READY outputs drop the next cycle.
  - The FSM goes to RSP with rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0.
  - This is a recovery path only; a late slave response arriving afterwards is ignored.
- SLVERR/DECERR from the slave pass through in rsp_resp with rsp_timeout=0.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state=IDLE and all registered outputs 0. This covers AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout and the address/data registers. cmd_ready=1 after reset.
- Reset mid-transaction drops every VALID/READY immediately and no response is produced.
- Command accepted at cycle N → AWVALID/WVALID or ARVALID high at N+1 (registered).
- B or R handshake at cycle M → rsp_valid high at M+1.
- Zero-wait slave (READY high, B/R returned one cycle after address/data): write and read both give rsp_valid at N+3.
- Exactly one transaction is outstanding. cmd_ready=0 from N+1 until the cycle after the rsp handshake.
- Back-to-back: rsp handshake at cycle K → next command can be accepted at K+1.

## Test plan
- Write to 11'h000 with wdata 64'h0123_4567_89AB_CDEF, wstrb 8'hFF, zero-wait slave → AW/W presented at N+1 with those values; rsp_valid at N+3 with rsp_resp=0, rsp_rdata=0.
- Write with AWREADY delayed 4 cycles and WREADY immediate → WVALID drops after 1 cycle and AWVALID holds 4 cycles; BREADY is not asserted until both are done; rsp_resp equals the returned BRESP.
- Read from 11'h010 where the slave returns RDATA 64'hDEAD_BEEF_0000_0001, RRESP 2'b10 after a 3-cycle RVALID delay → rsp_rdata=64'hDEAD_BEEF_0000_0001, rsp_resp=2'b10, rsp_timeout=0.
- TIMEOUT_CYCLES=8 with a slave that never asserts ARREADY → ARVALID drops after 8 busy cycles; response is rsp_resp=2'b11, rsp_timeout=1; the next command is accepted normally.
- rsp_ready held low for 5 cycles → rsp_* stable and cmd_ready=0 throughout; a following back-to-back write is accepted the cycle after the handshake.
- M_AXI_ARESETN asserted while AWVALID=1 → all VALID/READY and rsp_valid are 0 immediately; cmd_ready=1 after release.
